// File: rtl/rhythm_judge_ctrl_pkg.sv
// Package: rhythm_pkg
// Shared definitions for the rhythm game controller: FSM state encoding,
// song IDs, shifter pixel-phase limit, and saturating-add helpers used for
// the score and hit/miss counters.
package rhythm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    PLAY   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic [1:0] SONG_NONE = 2'd0;
  localparam logic [1:0] SONG_1    = 2'd1;
  localparam logic [1:0] SONG_2    = 2'd2;
  localparam logic [1:0] SONG_3    = 2'd3;

  // Last pixel phase of a note slot; a 6 -> 0 transition is a slot advance.
  localparam logic [2:0] OFFSET_MAX = 3'd6;

  // Widths of the saturating accumulators.
  localparam int SCORE_W = 16;
  localparam int CNT_W   = 10;

  // Add with clamp to all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add_score(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] b
  );
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_add_cnt(
    input logic [CNT_W-1:0] a,
    input logic [1:0]       b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rhythm_judge_ctrl_if.sv
// Interface: rhythm_judge_ctrl_if
// Signals between the game controller and the note shifter.
//   note_R_judge / note_B_judge : note present at the judge slot (shifter -> ctrl)
//   offset                      : shifter pixel phase 0..6     (shifter -> ctrl)
//   combo                       : shifter combo count          (shifter -> ctrl)
//   finish                      : song ended                   (shifter -> ctrl)
//   song                        : selected song, 0 = none      (ctrl -> shifter)
//   delete                      : clear judged note            (ctrl -> shifter)
// Handshake: there is no valid/ready pair on this link. delete is a
// single-cycle pulse with no back-pressure; the shifter must consume it in
// the cycle it is high. All shifter outputs are plain levels sampled every
// clock.
interface rhythm_judge_ctrl_if;
  logic       note_R_judge;
  logic       note_B_judge;
  logic [2:0] offset;
  logic [7:0] combo;
  logic       finish;
  logic [1:0] song;
  logic       delete;

  modport master (
    input  note_R_judge, note_B_judge, offset, combo, finish,
    output song, delete
  );

  modport slave (
    output note_R_judge, note_B_judge, offset, combo, finish,
    input  song, delete
  );
endinterface

// File: rtl/rhythm_judge_ctrl_rise_detect.sv
// Module: rise_detect
// 1-bit rising-edge detector. The previous level is registered; rise is
// high in the cycle where level is 1 and the registered level is 0.
//   clk   : clock
//   rst   : synchronous active-high reset (clears history)
//   level : input level
//   rise  : rising-edge pulse
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;
endmodule

// File: rtl/rhythm_judge_ctrl.sv
// Module: rhythm_judge_ctrl
// Game-flow controller and hit judge for the LED-matrix note shifter.
// Sequences IDLE -> SELECT -> PLAY -> RESULT, drives the shifter's song
// select and note delete, judges red/blue presses against the judge slot and
// accumulates score, hit/miss counts and max combo.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   red/blue/yellow/sel_button    : debounced button levels
//   shf (master)                  : shifter link (notes, offset, combo,
//                                   finish in; song, delete out)
//   song_sel                      : highlighted song in SELECT, 1..3
//   score, hit_count, miss_count  : saturating statistics
//   max_combo                     : highest combo seen this song
//   state                         : FSM state (IDLE=0 SELECT=1 PLAY=2 RESULT=3)
// Build option: define RHYTHM_COMBO_BONUS_EN to double hit points while
// combo >= COMBO_BONUS_TH.
module rhythm_judge_ctrl
  import rhythm_pkg::*;
#(
  parameter int PERFECT_LO     = 2,
  parameter int PERFECT_HI     = 4,
  parameter int PERFECT_PTS    = 3,
  parameter int GOOD_PTS       = 1,
  parameter int COMBO_BONUS_TH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               red_button,
  input  logic               blue_button,
  input  logic               yellow_button,
  input  logic               sel_button,
  rhythm_judge_ctrl_if.master shf,
  output logic [1:0]         song_sel,
  output logic [SCORE_W-1:0] score,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count,
  output logic [7:0]         max_combo,
  output logic [1:0]         state
);

`ifdef RHYTHM_COMBO_BONUS_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  // ---------------- button edge detection ----------------
  logic red_rise, blue_rise, yel_rise, sel_rise;

  rise_detect u_red    (.clk(clk), .rst(rst), .level(red_button),    .rise(red_rise));
  rise_detect u_blue   (.clk(clk), .rst(rst), .level(blue_button),   .rise(blue_rise));
  rise_detect u_yellow (.clk(clk), .rst(rst), .level(yellow_button), .rise(yel_rise));
  rise_detect u_sel    (.clk(clk), .rst(rst), .level(sel_button),    .rise(sel_rise));

  // ---------------- game-flow FSM ----------------
  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (yel_rise)   state_d = SELECT;
      SELECT:  if (yel_rise)   state_d = PLAY;
      PLAY:    if (shf.finish) state_d = RESULT;
      RESULT:  if (yel_rise)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

  logic start_play;
  assign start_play = (state_q == SELECT) && yel_rise;

  // ---------------- song selection ----------------
  logic [1:0] song_sel_q, song_q;

  // Yellow wins over a simultaneous sel rise so the confirmed song is the
  // one that was highlighted.
  always_ff @(posedge clk) begin
    if (rst) begin
      song_sel_q <= SONG_1;
    end else if (state_q == SELECT && sel_rise && !yel_rise) begin
      song_sel_q <= (song_sel_q == SONG_3) ? SONG_1 : song_sel_q + 2'd1;
    end
  end

  // Registered from the next state so song is valid in the first PLAY cycle.
  always_ff @(posedge clk) begin
    if (rst) song_q <= SONG_NONE;
    else     song_q <= (state_d == PLAY) ? song_sel_q : SONG_NONE;
  end

  assign song_sel = song_sel_q;
  assign shf.song = song_q;

  // ---------------- slot tracking ----------------
  logic [2:0] offset_prev_q;
  logic       note_prev_q;
  logic       lock_q;
  logic       wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_prev_q <= 3'd0;
      note_prev_q   <= 1'b0;
    end else begin
      offset_prev_q <= shf.offset;
      note_prev_q   <= shf.note_R_judge | shf.note_B_judge;
    end
  end

  assign wrap = (offset_prev_q == OFFSET_MAX) && (shf.offset == 3'd0);

  // ---------------- judge ----------------
  logic hit, wrong, unhit, perfect;

  always_comb begin
    hit   = 1'b0;
    wrong = 1'b0;
    if (state_q == PLAY && !lock_q) begin
      if (red_rise && blue_rise) begin
        wrong = 1'b1;
      end else if (red_rise) begin
        if (shf.note_R_judge) hit = 1'b1;
        else                  wrong = 1'b1;
      end else if (blue_rise) begin
        if (shf.note_B_judge) hit = 1'b1;
        else                  wrong = 1'b1;
      end
    end
  end

  // A note that was at the judge slot when the slot advanced without a hit.
  assign unhit   = (state_q == PLAY) && wrap && !lock_q && note_prev_q;
  assign perfect = (int'(shf.offset) >= PERFECT_LO) && (int'(shf.offset) <= PERFECT_HI);

  logic [SCORE_W-1:0] pts_base, pts;
  logic               bonus;

  assign pts_base = perfect ? SCORE_W'(PERFECT_PTS) : SCORE_W'(GOOD_PTS);
  assign bonus    = BONUS_EN && (int'(shf.combo) >= COMBO_BONUS_TH);
  assign pts      = bonus ? (pts_base << 1) : pts_base;

  logic [1:0] miss_inc;
  assign miss_inc = {1'b0, wrong} + {1'b0, unhit};

  // Judging uses the lock value from before this cycle; a slot advance in
  // the same cycle then clears it, overriding a lock set by that hit.
  always_ff @(posedge clk) begin
    if (rst)             lock_q <= 1'b0;
    else if (start_play) lock_q <= 1'b0;
    else if (wrap)       lock_q <= 1'b0;
    else if (hit)        lock_q <= 1'b1;
  end

  // ---------------- statistics ----------------
  logic [SCORE_W-1:0] score_q;
  logic [CNT_W-1:0]   hit_q, miss_q;
  logic [7:0]         max_combo_q;

  always_ff @(posedge clk) begin
    if (rst || start_play) begin
      score_q     <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      max_combo_q <= '0;
    end else if (state_q == PLAY) begin
      if (hit) begin
        score_q <= sat_add_score(score_q, pts);
        hit_q   <= sat_add_cnt(hit_q, 2'd1);
      end
      if (miss_inc != 2'd0) miss_q <= sat_add_cnt(miss_q, miss_inc);
      if (shf.combo > max_combo_q) max_combo_q <= shf.combo;
    end
  end

  assign score      = score_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign max_combo  = max_combo_q;

  // ---------------- delete pulse ----------------
  logic delete_q;

  always_ff @(posedge clk) begin
    if (rst) delete_q <= 1'b0;
    else     delete_q <= hit;
  end

  // Masked by rst so a pending pulse drops in the same cycle reset rises.
  assign shf.delete = delete_q & ~rst;

endmodule

// File: tb/tb_rhythm_judge_ctrl.sv
// Directed bench for rhythm_judge_ctrl: walks select -> play -> result,
// hit/miss judging, slot-advance misses, max combo, score saturation and a
// mid-play reset.
module tb_rhythm_judge_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic red_button, blue_button, yellow_button, sel_button;
  logic [1:0]  song_sel;
  logic [15:0] score;
  logic [9:0]  hit_count, miss_count;
  logic [7:0]  max_combo;
  logic [1:0]  state;

  rhythm_judge_ctrl_if shf ();

  rhythm_judge_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .red_button   (red_button),
    .blue_button  (blue_button),
    .yellow_button(yellow_button),
    .sel_button   (sel_button),
    .shf          (shf),
    .song_sel     (song_sel),
    .score        (score),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .max_combo    (max_combo),
    .state        (state)
  );

  // ---------------- scoreboard ----------------
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_yellow();
    yellow_button = 1'b1; step();
    yellow_button = 1'b0; step();
  endtask

  task automatic pulse_sel();
    sel_button = 1'b1; step();
    sel_button = 1'b0; step();
  endtask

  logic [15:0] exp_bonus_score;

  initial begin
    rst = 1'b1;
    red_button = 0; blue_button = 0; yellow_button = 0; sel_button = 0;
    shf.note_R_judge = 0; shf.note_B_judge = 0;
    shf.offset = 3'd0; shf.combo = 8'd0; shf.finish = 1'b0;
    step(); step();

    // Reset state
    check("rst_state",    state, 0);
    check("rst_song",     shf.song, 0);
    check("rst_song_sel", song_sel, 1);
    check("rst_delete",   shf.delete, 0);
    check("rst_score",    score, 0);
    check("rst_hits",     hit_count, 0);
    check("rst_miss",     miss_count, 0);
    check("rst_maxc",     max_combo, 0);
    rst = 1'b0;
    step();

    // 1. IDLE -> SELECT, cycle to song 3, -> PLAY
    yellow_button = 1'b1; step();
    check("sel_state", state, 1);
    check("sel_song",  shf.song, 0);
    check("sel_sel1",  song_sel, 1);
    yellow_button = 1'b0; step();
    pulse_sel();
    check("sel_sel2", song_sel, 2);
    pulse_sel();
    check("sel_sel3", song_sel, 3);
    // Simultaneous sel and yellow: yellow wins, song_sel held
    yellow_button = 1'b1; sel_button = 1'b1; step();
    check("play_state", state, 2);
    check("play_song",  shf.song, 3);
    check("play_sel_held", song_sel, 3);
    yellow_button = 1'b0; sel_button = 1'b0; step();

    // 2. Perfect red hit, then a locked second press
    shf.note_R_judge = 1; shf.offset = 3'd3; red_button = 1; step();
    check("hit1_delete", shf.delete, 1);
    check("hit1_score",  score, 3);
    check("hit1_hits",   hit_count, 1);
    red_button = 0; step();
    check("hit1_delete_off", shf.delete, 0);
    red_button = 1; step();
    check("locked_delete", shf.delete, 0);
    check("locked_score",  score, 3);
    check("locked_hits",   hit_count, 1);
    check("locked_miss",   miss_count, 0);
    red_button = 0; step();

    // 3. Unlock via wrap (lock was set, so no unhit miss), good blue hit
    shf.offset = 3'd6; step();
    shf.offset = 3'd0; step();
    check("wrap1_miss", miss_count, 0);
    shf.note_R_judge = 0; shf.note_B_judge = 1; shf.offset = 3'd6; blue_button = 1; step();
    check("hit2_score",  score, 4);
    check("hit2_hits",   hit_count, 2);
    check("hit2_delete", shf.delete, 1);
    blue_button = 0; step();
    shf.offset = 3'd0; step();
    // Wrong colour
    shf.offset = 3'd1; red_button = 1; step();
    check("wrong_miss",   miss_count, 1);
    check("wrong_delete", shf.delete, 0);
    check("wrong_hits",   hit_count, 2);
    red_button = 0; step();

    // 4. Unpressed red note through a wrap, then red+blue together
    shf.note_B_judge = 0; shf.note_R_judge = 1; shf.offset = 3'd6; step();
    shf.offset = 3'd0; step();
    check("unhit_miss", miss_count, 2);
    shf.note_R_judge = 0; shf.offset = 3'd2; red_button = 1; blue_button = 1; step();
    check("both_miss",   miss_count, 3);
    check("both_delete", shf.delete, 0);
    red_button = 0; blue_button = 0; step();

    // 5. Max combo tracking and combo-threshold hit
    shf.combo = 8'd20; step();
    shf.combo = 8'd5;  step();
    check("maxc_20", max_combo, 20);
`ifdef RHYTHM_COMBO_BONUS_EN
    exp_bonus_score = 16'd10;
`else
    exp_bonus_score = 16'd7;
`endif
    shf.combo = 8'd16; shf.note_R_judge = 1; shf.offset = 3'd3; red_button = 1; step();
    check("combo16_score", score, {16'd0, exp_bonus_score});
    check("combo16_hits",  hit_count, 3);
    red_button = 0; step();

    // 6. Saturation at 16'hFFFF
    shf.combo = 8'd0;
    shf.offset = 3'd6; step();
    shf.offset = 3'd0; step();
    check("wrap3_miss", miss_count, 3);
    force dut.score_q = 16'hFFFE;
    #1;
    release dut.score_q;
    shf.offset = 3'd3; red_button = 1; step();
    check("sat_score", score, 16'hFFFF);
    check("sat_hits",  hit_count, 4);
    red_button = 0; step();

    // Finish -> RESULT, stats frozen, back to IDLE
    shf.note_R_judge = 0; shf.finish = 1; step();
    check("res_state", state, 3);
    check("res_song",  shf.song, 0);
    check("res_maxc",  max_combo, 20);
    shf.finish = 0;
    shf.combo = 8'd50; step();
    check("res_maxc_frozen", max_combo, 20);
    pulse_yellow();
    check("idle_state", state, 0);
    check("idle_score_hold", score, 16'hFFFF);
    shf.combo = 8'd0;

    // New song: stats cleared on SELECT -> PLAY
    pulse_yellow();
    yellow_button = 1; step();
    check("play2_state", state, 2);
    check("play2_score", score, 0);
    check("play2_hits",  hit_count, 0);
    check("play2_miss",  miss_count, 0);
    check("play2_maxc",  max_combo, 0);
    yellow_button = 0; step();

    // Reset mid-PLAY with a delete pulse pending
    shf.note_R_judge = 1; shf.offset = 3'd3; red_button = 1; step();
    check("play2_delete", shf.delete, 1);
    rst = 1; #1;
    check("rst_delete_now", shf.delete, 0);
    step();
    check("rst_mid_state",  state, 0);
    check("rst_mid_song",   shf.song, 0);
    check("rst_mid_delete", shf.delete, 0);
    rst = 0; red_button = 0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
